// File: rtl/crg_switch_ctrl_pkg.sv
// Shared types and sizing helpers for the clock/reset switch sequencer.
// Holds the FSM state encoding, default dwell lengths and width functions.
package crg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_ASSERT,
        GATE_OFF,
        WAIT_LOCK,
        SWITCH,
        GATE_ON,
        RST_RELEASE
    } crg_state_t;

    localparam int DEF_NUM_PLL       = 4;
    localparam int DEF_RST_CYCLES    = 4;
    localparam int DEF_GATE_CYCLES   = 4;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_LOCK_TIMEOUT  = 1024;

    // Width that holds the largest dwell value without wrapping.
    function automatic int crg_cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic int crg_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crg_switch_ctrl_if.sv
// Request handshake, PLL lock inputs and downstream clock/reset controls.
// master = requester/environment side, slave = the sequencer.
interface crg_switch_ctrl_if
    import crg_pkg::*;
#(
    parameter int NUM_PLL = DEF_NUM_PLL
);
    localparam int SEL_W = crg_sel_w(NUM_PLL);

    logic               req_valid_i;
    logic [SEL_W-1:0]   req_sel_i;
    logic               req_ready_o;
    logic [NUM_PLL-1:0] pll_locked_i;
    logic [SEL_W-1:0]   sel_o;
    logic               en_o;
    logic               arst_req_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    modport master (
        output req_valid_i, req_sel_i, pll_locked_i,
        input  req_ready_o, sel_o, en_o, arst_req_o, busy_o, done_o, err_o
    );

    modport slave (
        input  req_valid_i, req_sel_i, pll_locked_i,
        output req_ready_o, sel_o, en_o, arst_req_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/crg_switch_ctrl_wait_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
// Zero flag is combinational from the count register, no backpressure.
module crg_wait_counter #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/crg_switch_ctrl.sv
// Glitch-safe PLL source sequencer: reset, gate, lock, switch, ungate, release; bring-up after reset.
// Registered outputs; a request is acted on one cycle after accept, req_valid_i is ignored while busy.
module crg_switch_ctrl
    import crg_pkg::*;
#(
    parameter int NUM_PLL       = DEF_NUM_PLL,
    parameter int DEFAULT_SEL   = 0,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT
) (
    input  logic               ref_clk_i,
    input  logic               arst_i,
    crg_switch_ctrl_if.slave   bus
);

    localparam int SEL_W = crg_sel_w(NUM_PLL);
    localparam int CNT_W = crg_cnt_w(RST_CYCLES, GATE_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT);

    localparam logic [SEL_W-1:0] DEF_SEL   = SEL_W'(DEFAULT_SEL);
    localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_TIMEOUT - 1);

    crg_state_t       state_q, nxt_state;
    logic [SEL_W-1:0] target_q, nxt_target;
    logic [SEL_W-1:0] sel_q, nxt_sel;
    logic             pend_q, nxt_pend;
    logic             en_q, nxt_en;
    logic             arst_req_q, nxt_arst_req;
    logic             ready_q, nxt_ready;
    logic             busy_q, nxt_busy;
    logic             done_q, nxt_done;
    logic             err_q, nxt_err;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             tgt_locked;
    logic             tgt_illegal;

    // Counter resets already loaded for the bring-up WAIT_LOCK.
    crg_wait_counter #(
        .W       (CNT_W),
        .RST_VAL (LOCK_LD)
    ) u_wait_counter (
        .clk      (ref_clk_i),
        .rst      (arst_i),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        tgt_locked = 1'b0;
        for (int i = 0; i < NUM_PLL; i++) begin
            if (target_q == SEL_W'(i)) tgt_locked = bus.pll_locked_i[i];
        end
    end

    assign tgt_illegal = (int'(target_q) >= NUM_PLL);

    always_ff @(posedge ref_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= WAIT_LOCK;
            target_q   <= DEF_SEL;
            sel_q      <= DEF_SEL;
            pend_q     <= 1'b0;
            en_q       <= 1'b0;
            arst_req_q <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= nxt_state;
            target_q   <= nxt_target;
            sel_q      <= nxt_sel;
            pend_q     <= nxt_pend;
            en_q       <= nxt_en;
            arst_req_q <= nxt_arst_req;
            ready_q    <= nxt_ready;
            busy_q     <= nxt_busy;
            done_q     <= nxt_done;
            err_q      <= nxt_err;
        end
    end

    always_comb begin
        nxt_state    = state_q;
        nxt_target   = target_q;
        nxt_sel      = sel_q;
        nxt_pend     = 1'b0;
        nxt_en       = en_q;
        nxt_arst_req = arst_req_q;
        nxt_ready    = ready_q;
        nxt_done     = 1'b0;
        nxt_err      = err_q;
        cnt_load     = 1'b0;
        cnt_val      = LOCK_LD;

        unique case (state_q)
            IDLE: begin
                // pend_q marks the cycle after accept, when the latched target is judged.
                if (pend_q) begin
                    if (tgt_illegal) begin
                        nxt_err   = 1'b1;
                        nxt_done  = 1'b1;
                        nxt_ready = 1'b1;
                    end else if (target_q == sel_q) begin
                        nxt_done  = 1'b1;
                        nxt_ready = 1'b1;
                    end else begin
                        nxt_state    = RST_ASSERT;
                        nxt_arst_req = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_val      = RST_LD;
                    end
                end else if (bus.req_valid_i && ready_q) begin
                    nxt_target = bus.req_sel_i;
                    nxt_err    = 1'b0;
                    nxt_ready  = 1'b0;
                    nxt_pend   = 1'b1;
                end
            end
            RST_ASSERT: begin
                if (cnt_zero) begin
                    nxt_state = GATE_OFF;
                    nxt_en    = 1'b0;
                    cnt_load  = 1'b1;
                    cnt_val   = GATE_LD;
                end
            end
            GATE_OFF: begin
                if (cnt_zero) begin
                    nxt_state = WAIT_LOCK;
                    cnt_load  = 1'b1;
                    cnt_val   = LOCK_LD;
                end
            end
            WAIT_LOCK: begin
                if (tgt_locked) begin
                    nxt_state = SWITCH;
                    nxt_sel   = target_q;
                    cnt_load  = 1'b1;
                    cnt_val   = SETTLE_LD;
                end else if (cnt_zero) begin
                    // Lock never came: keep the running source and bring the clock back.
                    nxt_state  = GATE_ON;
                    nxt_err    = 1'b1;
                    nxt_target = sel_q;
                    nxt_en     = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = GATE_LD;
                end
            end
            SWITCH: begin
                if (cnt_zero) begin
                    nxt_state = GATE_ON;
                    nxt_en    = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = GATE_LD;
                end
            end
            GATE_ON: begin
                if (cnt_zero) begin
                    nxt_state    = RST_RELEASE;
                    nxt_arst_req = 1'b0;
                    nxt_done     = 1'b1;
                end
            end
            RST_RELEASE: begin
                nxt_state = IDLE;
                nxt_ready = 1'b1;
            end
            default: begin
                nxt_state = IDLE;
                nxt_ready = 1'b1;
            end
        endcase

        nxt_busy = (nxt_state != IDLE);
    end

    assign bus.req_ready_o = ready_q;
    assign bus.sel_o       = sel_q;
    assign bus.en_o        = en_q;
    assign bus.arst_req_o  = arst_req_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;

endmodule
